// File: rtl/cn_r_vec_if.sv
// Beat-level bus for cn_r_vec: row-state input side and c2v output side, each with valid/ready.
interface cn_r_vec_if #(
  parameter int unsigned MSG_WIDTH   = 6,
  parameter int unsigned COL_CNT_WID = 7,
  parameter int unsigned LANES       = 4
);
  logic                             i_valid;
  logic                             o_ready;
  logic [LANES*(MSG_WIDTH-1)-1:0]   i_min0;
  logic [LANES*(MSG_WIDTH-1)-1:0]   i_min1;
  logic [LANES*COL_CNT_WID-1:0]     i_idx0;
  logic [LANES-1:0]                 i_sign;
  logic [LANES-1:0]                 i_sign_tot;
  logic [COL_CNT_WID-1:0]           i_col_cnt;
  logic                             i_first_iter;
  logic [1:0]                       i_mode;
  logic                             o_valid;
  logic                             i_ready;
  logic [LANES*MSG_WIDTH-1:0]       o_c2v;

  modport master (
    output i_valid, i_min0, i_min1, i_idx0, i_sign, i_sign_tot, i_col_cnt, i_first_iter,
           i_mode, i_ready,
    input  o_ready, o_valid, o_c2v
  );

  modport slave (
    input  i_valid, i_min0, i_min1, i_idx0, i_sign, i_sign_tot, i_col_cnt, i_first_iter,
           i_mode, i_ready,
    output o_ready, o_valid, o_c2v
  );
endinterface

// File: rtl/cn_r_vec.sv
// Multi-lane 2-stage check-node recover unit: rebuilds c2v messages from min-sum row state.
// Optional clipped-lane counter enabled by defining CN_R_CLIP_CNT_EN.
module cn_r_vec #(
  parameter int unsigned MSG_WIDTH   = 6,
  parameter int unsigned COL_CNT_WID = 7,
  parameter int unsigned LANES       = 4,
  parameter int unsigned OFFSET_BETA = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
`ifdef CN_R_CLIP_CNT_EN
  input  logic        i_cnt_clr,
  output logic [15:0] o_clip_cnt,
`endif
  cn_r_vec_if.slave   bus
);
  localparam int unsigned MW = MSG_WIDTH - 1;
  localparam int unsigned CW = COL_CNT_WID;

  logic en;

  logic                          s1_valid_d, s1_valid_q;
  logic [LANES-1:0][MW-1:0]      s1_mag_d, s1_mag_q;
  logic [LANES-1:0]              s1_rsign_d, s1_rsign_q;
  logic [1:0]                    s1_mode_d, s1_mode_q;
  logic                          s1_first_d, s1_first_q;

  logic                          out_valid_d, out_valid_q;
  logic [LANES*MSG_WIDTH-1:0]    c2v_d, c2v_q;

  logic [LANES-1:0][MW-1:0]      cm;
  logic [LANES-1:0][MSG_WIDTH:0] scaled3;

  assign en          = ~out_valid_q | bus.i_ready;
  assign bus.o_ready = en;
  assign bus.o_valid = out_valid_q;
  assign bus.o_c2v   = c2v_q;

  // Stage 1: pick the excluded-minimum magnitude per lane.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mag_d   = s1_mag_q;
    s1_rsign_d = s1_rsign_q;
    s1_mode_d  = s1_mode_q;
    s1_first_d = s1_first_q;
    if (en) begin
      s1_valid_d = bus.i_valid;
      s1_rsign_d = bus.i_sign ^ bus.i_sign_tot;
      s1_mode_d  = bus.i_mode;
      s1_first_d = bus.i_first_iter;
      for (int k = 0; k < LANES; k++) begin
        s1_mag_d[k] = (bus.i_col_cnt == bus.i_idx0[k*CW +: CW]) ? bus.i_min1[k*MW +: MW]
                                                               : bus.i_min0[k*MW +: MW];
      end
    end
  end

  // Stage 2: min-sum correction and sign application.
  always_comb begin
    out_valid_d = out_valid_q;
    c2v_d       = c2v_q;
    for (int k = 0; k < LANES; k++) begin
      // mag*3 as mag + 2*mag, wide enough that >>2 never truncates
      scaled3[k] = {2'b00, s1_mag_q[k]} + {1'b0, s1_mag_q[k], 1'b0};
      unique case (s1_mode_q)
        2'b00:   cm[k] = scaled3[k][MW+1:2];
        2'b01:   cm[k] = (s1_mag_q[k] > MW'(OFFSET_BETA)) ? s1_mag_q[k] - MW'(OFFSET_BETA)
                                                          : '0;
        2'b10:   cm[k] = s1_mag_q[k];
        default: cm[k] = {1'b0, s1_mag_q[k][MW-1:1]};
      endcase
    end
    if (en) begin
      out_valid_d = s1_valid_q;
      for (int k = 0; k < LANES; k++) begin
        if (s1_first_q) begin
          c2v_d[k*MSG_WIDTH +: MSG_WIDTH] = '0;
        end else if (s1_rsign_q[k]) begin
          c2v_d[k*MSG_WIDTH +: MSG_WIDTH] = MSG_WIDTH'(0) - {1'b0, cm[k]};
        end else begin
          c2v_d[k*MSG_WIDTH +: MSG_WIDTH] = {1'b0, cm[k]};
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mag_q    <= '0;
      s1_rsign_q  <= '0;
      s1_mode_q   <= 2'b00;
      s1_first_q  <= 1'b0;
      out_valid_q <= 1'b0;
      c2v_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mag_q    <= s1_mag_d;
      s1_rsign_q  <= s1_rsign_d;
      s1_mode_q   <= s1_mode_d;
      s1_first_q  <= s1_first_d;
      out_valid_q <= out_valid_d;
      c2v_q       <= c2v_d;
    end
  end

`ifdef CN_R_CLIP_CNT_EN
  logic [15:0] clip_cnt_d, clip_cnt_q;
  logic [15:0] clip_inc;
  logic [16:0] clip_sum;

  // A lane is clipped when offset correction wipes out a nonzero magnitude.
  always_comb begin
    clip_inc = '0;
    for (int k = 0; k < LANES; k++) begin
      if (s1_mode_q == 2'b01 && s1_mag_q[k] != '0 && cm[k] == '0 && !s1_first_q) begin
        clip_inc = clip_inc + 16'd1;
      end
    end
    clip_sum   = {1'b0, clip_cnt_q} + {1'b0, clip_inc};
    clip_cnt_d = clip_cnt_q;
    if (i_cnt_clr) begin
      clip_cnt_d = '0;
    end else if (en && s1_valid_q) begin
      clip_cnt_d = clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clip_cnt_q <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign o_clip_cnt = clip_cnt_q;
`endif

endmodule

// File: tb/tb_cn_r_vec.sv
// Self-checking bench for cn_r_vec (MSG_WIDTH=6, LANES=4, OFFSET_BETA=1), with a queue scoreboard.
module tb_cn_r_vec;
  localparam int MSGW = 6;
  localparam int CWID = 7;
  localparam int NL   = 4;

  typedef struct {
    logic [NL*(MSGW-1)-1:0] min0;
    logic [NL*(MSGW-1)-1:0] min1;
    logic [NL*CWID-1:0]     idx0;
    logic [NL-1:0]          sgn;
    logic [NL-1:0]          tot;
    logic [CWID-1:0]        col;
    logic                   first;
    logic [1:0]             mode;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [NL*MSGW-1:0] exp_q[$];

`ifdef CN_R_CLIP_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] clip_cnt;
`endif

  always #5 clk = ~clk;

  cn_r_vec_if #(.MSG_WIDTH(MSGW), .COL_CNT_WID(CWID), .LANES(NL)) bus ();

  cn_r_vec #(
    .MSG_WIDTH(MSGW), .COL_CNT_WID(CWID), .LANES(NL), .OFFSET_BETA(1)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
`ifdef CN_R_CLIP_CNT_EN
    .i_cnt_clr (cnt_clr),
    .o_clip_cnt(clip_cnt),
`endif
    .bus       (bus)
  );

  // Reference: per-lane integer arithmetic straight from the min-sum rules.
  function automatic logic [NL*MSGW-1:0] model_c2v(input beat_t b);
    logic [NL*MSGW-1:0] r;
    int mag, cm, v;
    r = '0;
    for (int k = 0; k < NL; k++) begin
      mag = (b.col == b.idx0[k*CWID +: CWID]) ? int'(b.min1[k*5 +: 5]) : int'(b.min0[k*5 +: 5]);
      case (b.mode)
        2'd0:    cm = (mag * 3) / 4;
        2'd1:    cm = (mag > 1) ? mag - 1 : 0;
        2'd2:    cm = mag;
        default: cm = mag / 2;
      endcase
      v = b.first ? 0 : (((b.sgn[k] ^ b.tot[k]) != 0) ? -cm : cm);
      r[k*MSGW +: MSGW] = v[MSGW-1:0];
    end
    return r;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.min0  = NL*(MSGW-1)'($urandom);
    b.min1  = NL*(MSGW-1)'($urandom);
    b.col   = CWID'($urandom_range(7));
    for (int k = 0; k < NL; k++) b.idx0[k*CWID +: CWID] = CWID'($urandom_range(7));
    b.sgn   = NL'($urandom);
    b.tot   = NL'($urandom);
    b.first = ($urandom_range(7) == 0);
    b.mode  = 2'($urandom);
    return b;
  endfunction

  task automatic drive_beat(input beat_t b);
    bus.i_min0       = b.min0;
    bus.i_min1       = b.min1;
    bus.i_idx0       = b.idx0;
    bus.i_sign       = b.sgn;
    bus.i_sign_tot   = b.tot;
    bus.i_col_cnt    = b.col;
    bus.i_first_iter = b.first;
    bus.i_mode       = b.mode;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_valid);
    end
    n_tests++;
    if (bus.o_c2v !== '0) begin
      n_fail++; $display("FAIL reset_c2v: got %h want 0", bus.o_c2v);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", bus.o_ready);
    end
  endtask

  task automatic test_scale34();
    beat_t b;
    b.min0 = {4{5'd8}};
    b.min1 = {4{5'd12}};
    b.idx0 = {4{7'd3}};
    b.col = 7'd3; b.sgn = 4'b0000; b.tot = 4'b1111; b.first = 1'b0; b.mode = 2'b00;
    @(negedge clk);
    drive_beat(b); bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    n_tests++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL scale34_early: o_valid got %b want 0", bus.o_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_c2v !== {4{6'h37}}) begin
      n_fail++; $display("FAIL scale34: valid %b c2v %h want 1 %h", bus.o_valid, bus.o_c2v,
                         {4{6'h37}});
    end
    @(negedge clk);
  endtask

  task automatic test_offset();
    beat_t b;
    b.min0 = {5'd0, 5'd2, 5'd31, 5'd1};
    b.min1 = {4{5'd17}};
    b.idx0 = '0;
    b.col = 7'd5; b.sgn = 4'b1101; b.tot = 4'b0000; b.first = 1'b0; b.mode = 2'b01;
`ifdef CN_R_CLIP_CNT_EN
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
`endif
    @(negedge clk);
    drive_beat(b); bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_c2v !== {6'd0, 6'h3F, 6'd30, 6'd0}) begin
      n_fail++; $display("FAIL offset: valid %b c2v %h want 1 %h", bus.o_valid, bus.o_c2v,
                         {6'd0, 6'h3F, 6'd30, 6'd0});
    end
`ifdef CN_R_CLIP_CNT_EN
    n_tests++;
    if (clip_cnt !== 16'd1) begin
      n_fail++; $display("FAIL offset_clip: cnt %0d want 1", clip_cnt);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_first_iter();
    beat_t b;
    b = rand_beat();
    b.first = 1'b1;
    b.min0 = {4{5'd21}};
    @(negedge clk);
    drive_beat(b); bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_c2v !== '0) begin
      n_fail++; $display("FAIL first_iter: valid %b c2v %h want 1 0", bus.o_valid, bus.o_c2v);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    beat_t bb[4];
    int sent, got;
    logic stall;
    for (int i = 0; i < 4; i++) begin
      bb[i] = rand_beat();
      bb[i].first = 1'b0;
    end
    exp_q.delete();
    sent = 0; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      stall = (c >= 3 && c <= 5);
      if (bus.o_valid) begin
        n_tests++;
        if (exp_q.size() == 0 || bus.o_c2v !== exp_q[0]) begin
          n_fail++; $display("FAIL bp_data: cycle %0d got %h want %h", c, bus.o_c2v,
                             (exp_q.size() != 0) ? exp_q[0] : '0);
        end
      end
      bus.i_ready = !stall;
      if (sent < 4) begin
        drive_beat(bb[sent]); bus.i_valid = 1'b1;
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (c == 3) begin
        n_tests++;
        if (got != 1 || bus.o_valid !== 1'b1) begin
          n_fail++; $display("FAIL bp_beat1_at_out: delivered %0d valid %b want 1 1", got,
                             bus.o_valid);
        end
      end
      if (stall) begin
        n_tests++;
        if (bus.o_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_ready: cycle %0d got %b want 0", c, bus.o_ready);
        end
      end
      if (bus.o_valid && !stall && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        got++;
      end
      if (sent < 4 && bus.o_ready) begin
        exp_q.push_back(model_c2v(bb[sent]));
        sent++;
      end
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    n_tests++;
    if (got != 4 || sent != 4) begin
      n_fail++; $display("FAIL bp_count: delivered %0d sent %0d want 4 4", got, sent);
    end
    @(negedge clk);
  endtask

  task automatic test_midreset();
    beat_t b0, b1, b2;
    b0 = rand_beat(); b1 = rand_beat(); b2 = rand_beat();
    b0.first = 1'b0; b1.first = 1'b0; b2.first = 1'b0;
    b2.min0 = {4{5'd20}}; b2.min1 = {4{5'd20}}; b2.mode = 2'b10; b2.tot = 4'b0101;
    @(negedge clk);
    drive_beat(b0); bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    @(negedge clk);
    drive_beat(b1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.o_valid !== 1'b0 || bus.o_c2v !== '0) begin
      n_fail++; $display("FAIL midreset_clear: valid %b c2v %h want 0 0", bus.o_valid,
                         bus.o_c2v);
    end
    rst_n = 1'b1;
    drive_beat(b2); bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    n_tests++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_stale: o_valid got %b want 0", bus.o_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_c2v !== model_c2v(b2)) begin
      n_fail++; $display("FAIL midreset_post: valid %b c2v %h want 1 %h", bus.o_valid,
                         bus.o_c2v, model_c2v(b2));
    end
    @(negedge clk);
    n_tests++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_alone: o_valid got %b want 0", bus.o_valid);
    end
  endtask

  task automatic test_random();
    beat_t b;
    logic vld, rdy, en;
    exp_q.delete();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious: cycle %0d c2v %h want no beat", c, bus.o_c2v);
        end else if (bus.o_c2v !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_data: cycle %0d got %h want %h", c, bus.o_c2v, exp_q[0]);
        end
      end
      rdy = ($urandom_range(9) < 7);
      vld = (c < 280) && ($urandom_range(9) < 7);
      b = rand_beat();
      drive_beat(b);
      bus.i_valid = vld;
      bus.i_ready = rdy;
      #1;
      en = !bus.o_valid || rdy;
      n_tests++;
      if (bus.o_ready !== en) begin
        n_fail++; $display("FAIL rand_ready: cycle %0d got %b want %b", c, bus.o_ready, en);
      end
      if (bus.o_valid && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (vld && en) exp_q.push_back(model_c2v(b));
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        n_tests++;
        if (bus.o_c2v !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_drain: got %h want %h", bus.o_c2v, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0 || bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL rand_complete: pending %0d valid %b want 0 0", exp_q.size(),
                         bus.o_valid);
    end
  endtask

`ifdef CN_R_CLIP_CNT_EN
  task automatic test_clip();
    beat_t b;
    b.min0 = {5'd0, 5'd5, 5'd1, 5'd1};
    b.min1 = {4{5'd9}};
    b.idx0 = '0;
    b.col = 7'd2; b.sgn = 4'b0110; b.tot = 4'b0011; b.first = 1'b0; b.mode = 2'b01;
    bus.i_ready = 1'b1;
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    drive_beat(b); bus.i_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (clip_cnt !== 16'd6) begin
      n_fail++; $display("FAIL clip_count: got %0d want 6", clip_cnt);
    end
    cnt_clr = 1'b1;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (clip_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clip_clr_priority: got %0d want 0", clip_cnt);
    end
    cnt_clr = 1'b0;
    @(negedge clk);
    n_tests++;
    if (clip_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clip_clr_hold: got %0d want 0", clip_cnt);
    end
  endtask
`endif

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_min0 = '0; bus.i_min1 = '0; bus.i_idx0 = '0;
    bus.i_sign = '0; bus.i_sign_tot = '0; bus.i_col_cnt = '0;
    bus.i_first_iter = 1'b0; bus.i_mode = 2'b00;
    test_reset();
    test_scale34();
    test_offset();
    test_first_iter();
    test_backpressure();
    test_midreset();
    test_random();
`ifdef CN_R_CLIP_CNT_EN
    test_clip();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
